// File: rtl/tick_timer.sv
// Tick-driven interval timer: counts `period` ticks, then pulses `expired` for one cycle (one-shot or auto-reload).
// All outputs are registered, one edge of latency after start/stop/tick; there is no backpressure and every request is acted on immediately.
module tick_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] period,
    input  logic             periodic,
    output logic             busy,
    output logic             expired,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             mode_q, mode_d;
    logic             exp_q, exp_d;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        per_d   = per_q;
        mode_d  = mode_q;
        exp_d   = 1'b0;

        // start wins in either state; a zero period is an immediate completion
        if (start) begin
            per_d  = period;
            mode_d = periodic;
            if (period == '0) begin
                state_d = IDLE;
                rem_d   = '0;
                exp_d   = 1'b1;
            end else begin
                state_d = RUN;
                rem_d   = period;
            end
        end else if (state_q == RUN) begin
            if (stop) begin
                state_d = IDLE;
                rem_d   = '0;
            end else if (tick) begin
                if (rem_q > CNT_W'(1)) begin
                    rem_d = rem_q - CNT_W'(1);
                end else begin
                    exp_d = 1'b1;
                    if (mode_q) begin
                        rem_d = per_q;
                    end else begin
                        state_d = IDLE;
                        rem_d   = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            per_q   <= '0;
            mode_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            per_q   <= per_d;
            mode_q  <= mode_d;
            exp_q   <= exp_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign expired   = exp_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_tick_timer.sv
// Randomised and directed bench for tick_timer against a tick-counting reference model.
module tb_tick_timer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick, start, stop, periodic;
    logic [W-1:0] period;
    logic         busy, expired;
    logic [W-1:0] remaining;

    int tests = 0;
    int fails = 0;

    // Reference model: counts ticks since the last start rather than a down-counter.
    bit m_run, m_mode, m_exp;
    int m_per, m_n;

    tick_timer #(.CNT_W(W)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .period(period), .periodic(periodic),
        .busy(busy), .expired(expired), .remaining(remaining)
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] expv();
        int r;
        if (!m_run) r = 0;
        else if (m_mode) r = m_per - (m_n % m_per);
        else r = m_per - m_n;
        return {m_run, m_exp, r[W-1:0]};
    endfunction

    task automatic model_reset();
        m_run = 0; m_mode = 0; m_exp = 0; m_per = 0; m_n = 0;
    endtask

    task automatic model_edge(input bit s_rst, input bit s_start, input bit s_stop,
                              input bit s_tick, input bit s_mode, input int s_period);
        m_exp = 0;
        if (s_rst) begin
            model_reset();
        end else if (s_start) begin
            m_per = s_period; m_mode = s_mode; m_n = 0;
            if (s_period == 0) begin m_exp = 1; m_run = 0; end
            else m_run = 1;
        end else if (m_run) begin
            if (s_stop) m_run = 0;
            else if (s_tick) begin
                m_n++;
                if (m_mode) begin
                    if (m_n % m_per == 0) m_exp = 1;
                end else if (m_n == m_per) begin
                    m_exp = 1; m_run = 0;
                end
            end
        end
    endtask

    task automatic drive(input bit st, input bit sp, input bit tk, input int per, input bit pm);
        start = st; stop = sp; tick = tk; period = W'(per); periodic = pm;
    endtask

    task automatic step();
        bit s_rst, s_start, s_stop, s_tick, s_mode;
        int s_period;
        s_rst = rst; s_start = start; s_stop = stop; s_tick = tick;
        s_mode = periodic; s_period = int'(period);
        @(posedge clk);
        model_edge(s_rst, s_start, s_stop, s_tick, s_mode, s_period);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (3) step();
        if ({busy, expired, remaining} !== {2'b00, W'(0)}) begin
            fails++;
            $display("FAIL reset_state: got %b/%b/%0d want 0/0/0", busy, expired, remaining);
        end
        tests++;
        rst = 1'b0;
        step();
        if ({busy, expired, remaining} !== expv()) begin
            fails++;
            $display("FAIL reset_release: got %b/%b/%0d want %b", busy, expired, remaining, expv());
        end
        tests++;
    endtask

    task automatic test_oneshot();
        int pulses = 0;
        drive(1, 0, 0, 3, 0);
        step();
        drive(0, 0, 0, 0, 0);
        if ({busy, expired, remaining} !== {2'b10, W'(3)}) begin
            fails++;
            $display("FAIL oneshot_load: got %b/%b/%0d want 1/0/3", busy, expired, remaining);
        end
        tests++;
        for (int i = 0; i < 25; i++) begin
            tick = (i % 5 == 4);
            step();
            if (expired) pulses++;
            if ({busy, expired, remaining} !== expv()) begin
                fails++;
                $display("FAIL oneshot_cyc%0d: got %b/%b/%0d want %b", i, busy, expired, remaining, expv());
            end
            tests++;
        end
        tick = 1'b0;
        if (pulses != 1 || busy !== 1'b0 || remaining !== W'(0)) begin
            fails++;
            $display("FAIL oneshot_total: pulses %0d busy %b rem %0d want 1/0/0", pulses, busy, remaining);
        end
        tests++;
    endtask

    task automatic test_periodic();
        int pulses = 0;
        drive(1, 0, 0, 2, 1);
        step();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            tick = (i % 2 == 0);
            step();
            if (expired) pulses++;
            if ({busy, expired, remaining} !== expv()) begin
                fails++;
                $display("FAIL periodic_cyc%0d: got %b/%b/%0d want %b", i, busy, expired, remaining, expv());
            end
            tests++;
        end
        if (pulses != 3 || busy !== 1'b1 || remaining !== W'(1)) begin
            fails++;
            $display("FAIL periodic_total: pulses %0d busy %b rem %0d want 3/1/1", pulses, busy, remaining);
        end
        tests++;
        drive(0, 1, 0, 0, 0);
        step();
        stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        drive(1, 0, 0, 1, 1);
        step();
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (expired) pulses++;
            if ({busy, expired, remaining} !== {2'b11, W'(1)} || {busy, expired, remaining} !== expv()) begin
                fails++;
                $display("FAIL b2b_cyc%0d: got %b/%b/%0d want 1/1/1", i, busy, expired, remaining);
            end
            tests++;
        end
        drive(0, 0, 0, 0, 0);
        step();
        if (pulses != 4 || expired !== 1'b0) begin
            fails++;
            $display("FAIL b2b_total: pulses %0d exp %b want 4/0", pulses, expired);
        end
        tests++;
        drive(0, 1, 0, 0, 0);
        step();
        stop = 1'b0;
    endtask

    task automatic test_zero_period();
        drive(1, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        if ({busy, expired, remaining} !== {2'b01, W'(0)}) begin
            fails++;
            $display("FAIL zero_pulse: got %b/%b/%0d want 0/1/0", busy, expired, remaining);
        end
        tests++;
        step();
        if ({busy, expired, remaining} !== {2'b00, W'(0)}) begin
            fails++;
            $display("FAIL zero_after: got %b/%b/%0d want 0/0/0", busy, expired, remaining);
        end
        tests++;
    endtask

    task automatic test_stop_tick();
        drive(1, 0, 0, 2, 0);
        step();
        drive(0, 0, 1, 0, 0);
        step();
        drive(0, 1, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        if ({busy, expired, remaining} !== {2'b00, W'(0)} || {busy, expired, remaining} !== expv()) begin
            fails++;
            $display("FAIL stop_tick: got %b/%b/%0d want 0/0/0", busy, expired, remaining);
        end
        tests++;
    endtask

    task automatic test_restart();
        drive(1, 0, 0, 9, 0);
        step();
        drive(0, 0, 1, 0, 0);
        repeat (3) step();
        drive(1, 0, 1, 5, 0);
        step();
        drive(0, 0, 0, 0, 0);
        if ({busy, expired, remaining} !== {2'b10, W'(5)} || {busy, expired, remaining} !== expv()) begin
            fails++;
            $display("FAIL restart_tick: got %b/%b/%0d want 1/0/5", busy, expired, remaining);
        end
        tests++;
        drive(1, 0, 0, 16'hFFFF, 0);
        step();
        drive(0, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        if ({busy, expired, remaining} !== {2'b10, W'(16'hFFFE)}) begin
            fails++;
            $display("FAIL max_period: got %b/%b/%0d want 1/0/65534", busy, expired, remaining);
        end
        tests++;
        drive(0, 1, 0, 0, 0);
        step();
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        drive(1, 0, 0, 4, 1);
        step();
        drive(0, 0, 0, 0, 0);
        if (remaining !== W'(4)) begin
            fails++;
            $display("FAIL arst_pre: rem %0d want 4", remaining);
        end
        tests++;
        #2 rst = 1'b1;
        model_reset();
        #1;
        if ({busy, expired, remaining} !== {2'b00, W'(0)}) begin
            fails++;
            $display("FAIL arst_immediate: got %b/%b/%0d want 0/0/0", busy, expired, remaining);
        end
        tests++;
        tick = 1'b1;
        repeat (2) begin
            step();
            if (expired) pulses++;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (expired) pulses++;
            if ({busy, expired, remaining} !== expv()) begin
                fails++;
                $display("FAIL arst_after%0d: got %b/%b/%0d want %b", i, busy, expired, remaining, expv());
            end
            tests++;
        end
        tick = 1'b0;
        if (pulses != 0) begin
            fails++;
            $display("FAIL arst_pulses: got %0d want 0", pulses);
        end
        tests++;
    endtask

    task automatic test_random();
        int p;
        for (int i = 0; i < 1500; i++) begin
            p = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 6);
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 2) == 0, p, $urandom_range(0, 1) == 1);
            step();
            if ({busy, expired, remaining} !== expv()) begin
                fails++;
                $display("FAIL random_cyc%0d: got %b/%b/%0d want %b", i, busy, expired, remaining, expv());
            end
            tests++;
        end
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_back_to_back();
        test_zero_period();
        test_stop_tick();
        test_restart();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tick_timer.md
# tick_timer

Programmable tick-driven interval timer that consumes the single-cycle `tick` strobe from the clock-divider tick generators. It counts a loaded number of ticks, then emits a one-cycle `expired` pulse, in one-shot or auto-reload mode. Blinkers, timeouts and polling schedulers instantiate it so that each one does not need its own wide cycle counter.

## Interface
- `CNT_W`, 16, width of the period and remaining-count registers (maximum period 2^CNT_W−1 ticks)
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `tick`  in  1  one-cycle timebase strobe from the tick generator; only its level at a clock edge matters
- `start`  in  1  one-cycle request: latch `period` and `periodic`, then begin counting
- `stop`  in  1  one-cycle request: abort counting and return to IDLE
- `period`  in  CNT_W  interval length in ticks; sampled only when `start` is high
- `periodic`  in  1  1 = auto-reload, 0 = one-shot; sampled only when `start` is high
- `busy`  out  1  high while in RUN
- `expired`  out  1  one-cycle pulse when the interval completes
- `remaining`  out  CNT_W  ticks left in the current interval

## Operation
- Reset values: state IDLE, `busy`=0, `expired`=0, `remaining`=0, latched period=0, latched mode=0.
- The block has two states, IDLE and RUN.
- Latched registers: `per_q` and `mode_q` load only on an accepted `start`.
- IDLE:
  - `start` with `period`≠0: load `remaining`=`period`, go to RUN.
  - `start` with `period`=0: stay in IDLE and assert `expired` for one cycle (zero-length interval), keep `remaining`=0.
  - `tick` and `stop` are ignored.
- RUN, priority order (highest first):
  1. `start`: restart. Reload from the new `period` and `periodic`. A coincident `tick` is ignored. If the new `period`=0, follow the IDLE zero-length rule and go to IDLE.
  2. `stop`: go to IDLE, `remaining`=0, no `expired`, even if a coincident `tick` would have completed the interval.
  3. `tick` with `remaining`>1: decrement `remaining` by 1.
  4. `tick` with `remaining`=1:
     - Assert `expired`.
     - If `mode_q`=1: `remaining`=`per_q` and stay in RUN.
     - If `mode_q`=0: `remaining`=0 and go to IDLE.
  5. No `tick`: hold.
- Width rules:
  - `remaining` never underflows; in RUN it is always ≥1.
  - `per_q`=2^CNT_W−1 is legal and produces no overflow.
- `expired` is registered and high for exactly one cycle per completion. Consecutive completions (period 1 in auto-reload mode with back-to-back ticks) produce back-to-back pulses.
- Reset mid-interval: all outputs go to their reset values immediately (asynchronous), and no `expired` is emitted.

## Timing
- `start` sampled at edge k: `busy`=1 and `remaining`=`period` are visible after edge k.
- `tick` sampled at edge k: `remaining` updates after edge k.
- The final `tick` at edge k produces `expired`=1 during the cycle after edge k. `busy` falls at the same edge in one-shot mode.
- Completion time:
  - One-shot with `period`=N completes on the N-th tick sampled after the start edge.
  - Auto-reload repeats every N ticks with no lost tick at the reload boundary.
- `stop` at edge k: `busy`=0 and `remaining`=0 after edge k.
- No combinational path from any input to any output.

## Test plan
- Reset, then `start` with `period`=3, `periodic`=0, and ticks every 5 clocks: `remaining` steps 3→2→1→0, one `expired` pulse the cycle after the 3rd tick, `busy` drops with it, and later ticks are ignored.
- `start` with `period`=2, `periodic`=1, and 7 ticks: `expired` pulses after ticks 2, 4 and 6, `remaining` reads 1 after tick 7, `busy` stays 1.
- `period`=1, `periodic`=1, `tick` held high for 4 cycles: 4 consecutive `expired` pulses, `remaining` stays 1.
- `start` with `period`=0: a single `expired` pulse the next cycle, `busy` stays 0.
- `remaining`=1 with `stop` and `tick` in the same cycle: no `expired`, `busy`=0. Separately, `start` (`period`=5) together with `tick` while in RUN: `remaining`=5, no decrement.
- Assert `rst` mid-count with `remaining`=4 and `periodic`=1: outputs are 0 immediately, with no `expired` before or after release.
